// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Cathode patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } seg_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Index 0 sits in the least significant slice, so digit F is listed first.
   localparam logic [15:0][6:0] HEX_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder with a blanking override.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_OFF : HEX_TABLE[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with anti-ghost guard cycles,
// leading-zero suppression and a once-per-frame snapshot of the inputs.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int GUARD   = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  ca,
   output logic        dp,
   output logic        frame_start
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);

   seg_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       idx_reg, idx_next;
   logic             capture;

   logic [15:0]      snap_value_reg;
   logic [3:0]       snap_dp_reg;
   logic             snap_lz_reg;

   logic [3:0]       an_reg, an_next;
   logic [6:0]       ca_reg, ca_next;
   logic             dp_reg, dp_next;
   logic             frame_start_reg;

   logic [3:0]       lz_blank;
   logic [6:0]       seg_dec;

   genvar gi;

   // Digit k is blanked when every digit from 3 down to k is zero.
   assign lz_blank[0] = 1'b0;
   for (gi = 1; gi < 4; gi++) begin : g_lz
      assign lz_blank[gi] = snap_lz_reg && (snap_value_reg[15:4*gi] == '0);
   end

   hex7seg u_hex7seg (
      .hex   (snap_value_reg[{idx_reg, 2'b00} +: 4]),
      .blank (lz_blank[idx_reg]),
      .seg   (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         idx_reg        <= '0;
         snap_value_reg <= '0;
         snap_dp_reg    <= '0;
         snap_lz_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         if (capture) begin
            snap_value_reg <= value;
            snap_dp_reg    <= dp_mask;
            snap_lz_reg    <= blank_lz;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      capture    = 1'b0;
      if (!enable) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
         idx_next   = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               capture    = 1'b1;
               state_next = ST_BLANK;
               cnt_next   = '0;
               idx_next   = '0;
            end
            ST_BLANK: begin
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == GUARD_LAST) state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
               if (cnt_reg == SLOT_LAST) begin
                  cnt_next   = '0;
                  idx_next   = idx_reg + 2'd1;
                  state_next = ST_BLANK;
                  capture    = (idx_reg == 2'd3);
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
               cnt_next   = '0;
               idx_next   = '0;
            end
         endcase
      end
   end

   // Guard cycles and IDLE are fully dark; only DRIVE lights a digit.
   always_comb begin
      an_next = 4'hF;
      ca_next = SEG_OFF;
      dp_next = 1'b1;
      if (state_reg == ST_DRIVE) begin
         an_next = ~(4'b0001 << idx_reg);
         ca_next = seg_dec;
         dp_next = ~snap_dp_reg[idx_reg];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an_reg          <= 4'hF;
         ca_reg          <= SEG_OFF;
         dp_reg          <= 1'b1;
         frame_start_reg <= 1'b0;
      end else begin
         an_reg          <= an_next;
         ca_reg          <= ca_next;
         dp_reg          <= dp_next;
         frame_start_reg <= capture;
      end
   end

   assign an          = an_reg;
   assign ca          = ca_reg;
   assign dp          = dp_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with CLK_DIV=8, GUARD=2.
module tb_seg_scan_driver;

   localparam int CLK_DIV = 8;
   localparam int GUARD   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic        blank_lz;
   logic [3:0]  an;
   logic [6:0]  ca;
   logic        dp;
   logic        frame_start;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] ca;
      logic       dp;
      logic       fs;
   } exp_t;

   always #5 clk = ~clk;

   seg_scan_driver #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .value       (value),
      .dp_mask     (dp_mask),
      .blank_lz    (blank_lz),
      .an          (an),
      .ca          (ca),
      .dp          (dp),
      .frame_start (frame_start)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
   endtask

   // Expected outputs sampled just after edge n, where edge 0 is the capture
   // edge out of IDLE. Outputs lag the state by one cycle; each slot is
   // 2 dark guard cycles followed by 6 lit cycles. tab = {d3,d2,d1,d0}.
   function automatic exp_t model(int n, logic [27:0] tab, logic [3:0] dpm);
      exp_t e;
      int   m, slot, pos;
      e.an = 4'hF;
      e.ca = 7'h7F;
      e.dp = 1'b1;
      e.fs = (n % 32 == 0);
      if (n > 0) begin
         m    = n - 1;
         slot = (m / 8) % 4;
         pos  = m % 8;
         if (pos >= 2) begin
            e.an = ~(4'b0001 << slot);
            e.ca = tab[slot*7 +: 7];
            e.dp = ~dpm[slot];
         end
      end
      return e;
   endfunction

   task automatic test_reset();
      exp_t        e;
      logic [27:0] tab = {7'h79, 7'h24, 7'h30, 7'h19};
      enable = 1'b1; value = 16'h1234; dp_mask = 4'h0; blank_lz = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({an, ca, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got an=%h ca=%h dp=%b fs=%b exp an=f ca=7f dp=1 fs=0",
                     i, an, ca, dp, frame_start);
         end
      end
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         step();
         e = model(n, tab, 4'h0);
         total++;
         if ({an, ca, dp, frame_start} !== e) begin
            bad++;
            $display("FAIL reset_release n=%0d got an=%h ca=%h dp=%b fs=%b exp an=%h ca=%h dp=%b fs=%b",
                     n, an, ca, dp, frame_start, e.an, e.ca, e.dp, e.fs);
         end
      end
   endtask

   task automatic test_basic_scan();
      exp_t        e;
      logic [27:0] tab = {7'h79, 7'h24, 7'h30, 7'h19};
      enable = 1'b1; value = 16'h1234; dp_mask = 4'h0; blank_lz = 1'b0;
      apply_reset();
      for (int n = 0; n <= 64; n++) begin
         step();
         e = model(n, tab, 4'h0);
         total++;
         if ({an, ca, dp, frame_start} !== e) begin
            bad++;
            $display("FAIL basic_scan n=%0d got an=%h ca=%h dp=%b fs=%b exp an=%h ca=%h dp=%b fs=%b",
                     n, an, ca, dp, frame_start, e.an, e.ca, e.dp, e.fs);
         end
      end
   endtask

   task automatic test_leading_zero();
      exp_t        e;
      logic [15:0] vals [4] = '{16'h0042, 16'h0000, 16'h0400, 16'h0042};
      logic        lzs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [27:0] tabs [4] = '{{7'h7F, 7'h7F, 7'h19, 7'h24},
                               {7'h7F, 7'h7F, 7'h7F, 7'h40},
                               {7'h7F, 7'h19, 7'h40, 7'h40},
                               {7'h40, 7'h40, 7'h19, 7'h24}};
      for (int v = 0; v < 4; v++) begin
         enable = 1'b1; value = vals[v]; dp_mask = 4'h0; blank_lz = lzs[v];
         apply_reset();
         for (int n = 0; n <= 32; n++) begin
            step();
            e = model(n, tabs[v], 4'h0);
            total++;
            if ({an, ca, dp, frame_start} !== e) begin
               bad++;
               $display("FAIL leading_zero val=%h lz=%b n=%0d got an=%h ca=%h dp=%b fs=%b exp an=%h ca=%h dp=%b fs=%b",
                        vals[v], lzs[v], n, an, ca, dp, frame_start, e.an, e.ca, e.dp, e.fs);
            end
         end
      end
   endtask

   task automatic test_no_tearing();
      exp_t        e;
      logic [27:0] tab_a = {7'h08, 7'h08, 7'h08, 7'h08};
      logic [27:0] tab_5 = {7'h12, 7'h12, 7'h12, 7'h12};
      enable = 1'b1; value = 16'hAAAA; dp_mask = 4'h0; blank_lz = 1'b0;
      apply_reset();
      for (int n = 0; n <= 64; n++) begin
         step();
         e = model(n, (n <= 32) ? tab_a : tab_5, 4'h0);
         total++;
         if ({an, ca, dp, frame_start} !== e) begin
            bad++;
            $display("FAIL no_tearing n=%0d got an=%h ca=%h dp=%b fs=%b exp an=%h ca=%h dp=%b fs=%b",
                     n, an, ca, dp, frame_start, e.an, e.ca, e.dp, e.fs);
         end
         if (n == 12) value = 16'h5555;
      end
   endtask

   task automatic test_disable();
      exp_t        e;
      logic [27:0] tab_a = {7'h79, 7'h24, 7'h30, 7'h19};
      logic [27:0] tab_b = {7'h40, 7'h40, 7'h46, 7'h40};
      enable = 1'b1; value = 16'h1234; dp_mask = 4'h0; blank_lz = 1'b0;
      apply_reset();
      for (int n = 0; n <= 21; n++) begin
         step();
         e = model(n, tab_a, 4'h0);
         total++;
         if ({an, ca, dp, frame_start} !== e) begin
            bad++;
            $display("FAIL disable_pre n=%0d got an=%h ca=%h dp=%b fs=%b exp an=%h ca=%h dp=%b fs=%b",
                     n, an, ca, dp, frame_start, e.an, e.ca, e.dp, e.fs);
         end
         if (n == 20) enable = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if ({an, ca, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL disable_dark cyc=%0d got an=%h ca=%h dp=%b fs=%b exp an=f ca=7f dp=1 fs=0",
                     i, an, ca, dp, frame_start);
         end
      end
      value  = 16'h00C0;
      enable = 1'b1;
      for (int n = 0; n <= 20; n++) begin
         step();
         e = model(n, tab_b, 4'h0);
         total++;
         if ({an, ca, dp, frame_start} !== e) begin
            bad++;
            $display("FAIL disable_restart n=%0d got an=%h ca=%h dp=%b fs=%b exp an=%h ca=%h dp=%b fs=%b",
                     n, an, ca, dp, frame_start, e.an, e.ca, e.dp, e.fs);
         end
      end
   endtask

   task automatic test_decimal_point();
      exp_t        e;
      logic [27:0] tab = {7'h0E, 7'h0E, 7'h0E, 7'h0E};
      enable = 1'b1; value = 16'hFFFF; dp_mask = 4'b0101; blank_lz = 1'b0;
      apply_reset();
      for (int n = 0; n <= 33; n++) begin
         step();
         e = model(n, tab, 4'b0101);
         total++;
         if ({an, ca, dp, frame_start} !== e) begin
            bad++;
            $display("FAIL decimal_point n=%0d got an=%h ca=%h dp=%b fs=%b exp an=%h ca=%h dp=%b fs=%b",
                     n, an, ca, dp, frame_start, e.an, e.ca, e.dp, e.fs);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      exp_t        e;
      logic [27:0] tab = {7'h00, 7'h19, 7'h24, 7'h79};
      enable = 1'b1; value = 16'h8421; dp_mask = 4'b1000; blank_lz = 1'b1;
      apply_reset();
      for (int n = 0; n <= 13; n++) step();
      rst = 1'b1;
      step();
      total++;
      if ({an, ca, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid got an=%h ca=%h dp=%b fs=%b exp an=f ca=7f dp=1 fs=0",
                  an, ca, dp, frame_start);
      end
      rst = 1'b0;
      for (int n = 0; n <= 32; n++) begin
         step();
         e = model(n, tab, 4'b1000);
         total++;
         if ({an, ca, dp, frame_start} !== e) begin
            bad++;
            $display("FAIL reset_mid_restart n=%0d got an=%h ca=%h dp=%b fs=%b exp an=%h ca=%h dp=%b fs=%b",
                     n, an, ca, dp, frame_start, e.an, e.ca, e.dp, e.fs);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; value = '0; dp_mask = '0; blank_lz = 1'b0;
      test_reset();
      test_basic_scan();
      test_leading_zero();
      test_no_tearing();
      test_disable();
      test_decimal_point();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
